// File: rtl/tug_war_pkg.sv
// Shared types, winner codes and LFSR tap table for the tug-of-war game core.
package tug_war_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_OVER = 2'd1,
    GAME_OVER  = 2'd2
  } game_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Maximal-length XNOR taps; tap n (1-based) maps to mask bit n-1.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] mask;
    mask = '0;
    case (width)
      8:       mask = 16'h00B8;  // 8,6,5,4
      9:       mask = 16'h0110;  // 9,5
      10:      mask = 16'h0240;  // 10,7
      11:      mask = 16'h0500;  // 11,9
      12:      mask = 16'h0829;  // 12,6,4,1
      13:      mask = 16'h100D;  // 13,4,3,1
      14:      mask = 16'h2015;  // 14,5,3,1
      15:      mask = 16'h6000;  // 15,14
      16:      mask = 16'hD008;  // 16,15,13,4
      default: mask = 16'h0240;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/tug_war_engine_lfsr.sv
// XNOR Fibonacci LFSR driving the computer opponent; resets to zero.
module lfsr_xnor_n
  import tug_war_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] rnd
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic fb_c;

  // XNOR feedback keeps all-zeros legal; all-ones is the unreachable lockup.
  assign fb_c = ~(^(rnd & TAPS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rnd <= '0;
    else       rnd <= {rnd[W-2:0], fb_c};
  end

endmodule

// File: rtl/tug_war_engine.sv
// Tug-of-war game core: position counter, round/game FSM, scores and CPU opponent.
module tug_war_engine
  import tug_war_pkg::*;
#(
  parameter int unsigned N_POS     = 9,
  parameter int unsigned SCORE_MAX = 7,
  parameter int unsigned LFSR_W    = 10,
  parameter int unsigned POS_W     = $clog2(N_POS),
  parameter int unsigned SCORE_W   = $clog2(SCORE_MAX + 1)
) (
  input  logic               clkSelect,
  input  logic               resetGame,
  input  logic               new_round,
  input  logic               p1_press,
  input  logic               p2_press,
  input  logic               cpu_mode,
  input  logic [LFSR_W-1:0]  difficulty,
  output logic [N_POS-1:0]   lights,
  output logic [POS_W-1:0]   pos,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         game_state,
  output logic [1:0]         winner
);

  localparam logic [POS_W-1:0]   CENTRE = POS_W'((N_POS - 1) / 2);
  localparam logic [POS_W-1:0]   LAST   = POS_W'(N_POS - 1);
  localparam logic [SCORE_W-1:0] SMAX   = SCORE_W'(SCORE_MAX);

  game_state_e        state_q, state_d;
  logic [POS_W-1:0]   pos_d;
  logic [N_POS-1:0]   lights_d;
  logic [SCORE_W-1:0] p1_score_d, p2_score_d, p1_inc_c, p2_inc_c;
  logic [1:0]         winner_d;
  logic [LFSR_W-1:0]  lfsr;
  logic               cpu_press_c, mv2_c;

  lfsr_xnor_n #(.W(LFSR_W)) u_lfsr (
    .clk   (clkSelect),
    .reset (resetGame),
    .rnd   (lfsr)
  );

  assign cpu_press_c = (difficulty > lfsr);
  assign mv2_c       = cpu_mode ? cpu_press_c : p2_press;
  assign p1_inc_c    = p1_score + SCORE_W'(1);
  assign p2_inc_c    = p2_score + SCORE_W'(1);

  always_ff @(posedge clkSelect or posedge resetGame) begin
    if (resetGame) begin
      state_q  <= PLAY;
      pos      <= CENTRE;
      lights   <= N_POS'(1) << CENTRE;
      p1_score <= '0;
      p2_score <= '0;
      winner   <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      pos      <= pos_d;
      lights   <= lights_d;
      p1_score <= p1_score_d;
      p2_score <= p2_score_d;
      winner   <= winner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos;
    p1_score_d = p1_score;
    p2_score_d = p2_score;
    winner_d   = winner;

    case (state_q)
      PLAY: begin
        if (new_round) begin
          pos_d = CENTRE;
        end else if (p1_press && !mv2_c && pos != '0) begin
          pos_d = pos - POS_W'(1);
        end else if (!p1_press && mv2_c && pos != LAST) begin
          pos_d = pos + POS_W'(1);
        end

        // A round ends on the very edge the light reaches either end.
        if (!new_round && pos_d == '0 && pos != '0) begin
          if (p1_score != SMAX) p1_score_d = p1_inc_c;
          winner_d = WIN_P1;
          state_d  = (p1_inc_c == SMAX) ? GAME_OVER : ROUND_OVER;
        end else if (!new_round && pos_d == LAST && pos != LAST) begin
          if (p2_score != SMAX) p2_score_d = p2_inc_c;
          winner_d = WIN_P2;
          state_d  = (p2_inc_c == SMAX) ? GAME_OVER : ROUND_OVER;
        end
      end

      ROUND_OVER: begin
        if (new_round) begin
          pos_d    = CENTRE;
          winner_d = WIN_NONE;
          state_d  = PLAY;
        end
      end

      GAME_OVER: begin
      end

      default: begin
        pos_d    = CENTRE;
        winner_d = WIN_NONE;
        state_d  = PLAY;
      end
    endcase

    lights_d = N_POS'(1) << pos_d;
  end

  assign game_state = 2'(state_q);

endmodule

// File: tb/tb_tug_war_engine.sv
// Directed + randomized bench for tug_war_engine against a behavioural game model.
module tb_tug_war_engine;

  localparam int N_POS = 9;
  localparam int SMAX  = 7;
  localparam int LW    = 10;
  localparam int C     = (N_POS - 1) / 2;

  logic          clkSelect = 1'b0;
  logic          resetGame = 1'b0;
  logic          new_round = 1'b0;
  logic          p1_press  = 1'b0;
  logic          p2_press  = 1'b0;
  logic          cpu_mode  = 1'b0;
  logic [LW-1:0] difficulty = '0;
  logic [N_POS-1:0] lights;
  logic [3:0]    pos;
  logic [2:0]    p1_score, p2_score;
  logic [1:0]    game_state, winner;

  int checks = 0;
  int errors = 0;

  int m_pos, m_s1, m_s2, m_state, m_win;
  logic [LW-1:0] m_lfsr;

  tug_war_engine #(.N_POS(N_POS), .SCORE_MAX(SMAX), .LFSR_W(LW)) dut (
    .clkSelect (clkSelect),
    .resetGame (resetGame),
    .new_round (new_round),
    .p1_press  (p1_press),
    .p2_press  (p2_press),
    .cpu_mode  (cpu_mode),
    .difficulty(difficulty),
    .lights    (lights),
    .pos       (pos),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .game_state(game_state),
    .winner    (winner)
  );

  always #5 clkSelect = ~clkSelect;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N_POS-1:0] exp_lights;
    exp_lights = N_POS'(1) << m_pos;
    check({tag, "_pos"},    32'(pos),        32'(m_pos));
    check({tag, "_lights"}, 32'(lights),     32'(exp_lights));
    check({tag, "_s1"},     32'(p1_score),   32'(m_s1));
    check({tag, "_s2"},     32'(p2_score),   32'(m_s2));
    check({tag, "_state"},  32'(game_state), 32'(m_state));
    check({tag, "_winner"}, 32'(winner),     32'(m_win));
  endtask

  function automatic void model_reset();
    m_pos = C; m_s1 = 0; m_s2 = 0; m_state = 0; m_win = 0; m_lfsr = '0;
  endfunction

  // Game rules evaluated on one clock edge, using the inputs present before it.
  function automatic void model_edge(input bit nr, input bit p1, input bit p2);
    bit mv2;
    mv2 = cpu_mode ? (int'(difficulty) > int'(m_lfsr)) : p2;
    if (m_state == 1) begin
      if (nr) begin m_pos = C; m_win = 0; m_state = 0; end
    end else if (m_state == 0) begin
      if (nr) m_pos = C;
      else if (p1 && !mv2) m_pos = m_pos - 1;
      else if (!p1 && mv2) m_pos = m_pos + 1;
      if (!nr && m_pos == 0) begin
        m_s1++; m_win = 1; m_state = (m_s1 == SMAX) ? 2 : 1;
      end else if (!nr && m_pos == N_POS - 1) begin
        m_s2++; m_win = 2; m_state = (m_s2 == SMAX) ? 2 : 1;
      end
    end
    m_lfsr = {m_lfsr[LW-2:0], ~(m_lfsr[9] ^ m_lfsr[6])};
  endfunction

  task automatic step(input bit nr, input bit p1, input bit p2, input string tag);
    new_round = nr; p1_press = p1; p2_press = p2;
    @(posedge clkSelect);
    model_edge(nr, p1, p2);
    #1;
    check_all(tag);
    new_round = 1'b0; p1_press = 1'b0; p2_press = 1'b0;
  endtask

  // Asynchronous reset applied between edges; outputs must respond at once.
  task automatic async_reset(input string tag);
    resetGame = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    resetGame = 1'b0;
    #1;
  endtask

  initial begin
    // 1: reset between edges
    #2;
    async_reset("rst1");
    check("rst1_lights_const", 32'(lights), 32'(9'b000010000));

    // 2: player 1 wins a round, then p2 ignored, then new round
    cpu_mode = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "p1_move");
    check("p1_win_score", 32'(p1_score), 32'd1);
    check("p1_win_state", 32'(game_state), 32'd1);
    step(1'b0, 1'b0, 1'b1, "ro_p2_ignored");
    step(1'b1, 1'b0, 1'b0, "ro_new_round");

    // 3: simultaneous presses cancel; new_round beats a press
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, "both");
    step(1'b1, 1'b1, 1'b0, "nr_prio");

    // 4: computer opponent at the difficulty extremes
    cpu_mode = 1'b1;
    difficulty = '0;
    for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'(i & 1), "cpu_d0");
    difficulty = 10'h3FF;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "cpu_dmax");
    check("cpu_win_winner", 32'(winner), 32'd2);

    // 5: player 2 takes the game, then everything except reset is ignored
    for (int r = 0; r < 6; r++) begin
      step(1'b1, 1'b0, 1'b0, "g_nr");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "g_cpu");
    end
    check("go_state", 32'(game_state), 32'd2);
    check("go_s2", 32'(p2_score), 32'd7);
    for (int i = 0; i < 20; i++)
      step(1'(i % 3 == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "go_hold");
    async_reset("rst_go");

    // 6: reset mid-round at pos 2 with p1 on three wins
    cpu_mode = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "r6_p1");
      step(1'b1, 1'b0, 1'b0, "r6_nr");
    end
    step(1'b0, 1'b1, 1'b0, "r6_a");
    step(1'b0, 1'b1, 1'b0, "r6_b");
    check("r6_pos2", 32'(pos), 32'd2);
    check("r6_s1_3", 32'(p1_score), 32'd3);
    #2;
    async_reset("rst_mid");
    cpu_mode = 1'b1;
    difficulty = 10'd512;
    for (int i = 0; i < 40; i++) step(1'(i == 20), 1'b0, 1'b0, "lfsr_replay");

    // randomized play with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) difficulty = LW'($urandom);
      if (i % 25 == 0) cpu_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_war_engine.md
Name: tug_war_engine

Overview:
- Parametrised tug-of-war game core: a track of N_POS lights, a single lit position, round/game state machine, saturating score counters and an optional LFSR-driven computer opponent with programmable difficulty.
- Replaces the per-light chained mini-FSMs with one position counter plus one-hot decode, so track length, win target and opponent randomness are build-time parameters.
- Sits between the button synchronisers / switch inputs and the LED and 7-segment display drivers.

Parameters:
- N_POS, 9: number of track positions. Must be odd and >= 3. Centre index C = (N_POS-1)/2.
- SCORE_MAX, 7: round wins needed to end the game. Must be >= 1.
- LFSR_W, 10: opponent LFSR width. Supported range 8..16.
- POS_W, $clog2(N_POS): derived, do not override.
- SCORE_W, $clog2(SCORE_MAX+1): derived, do not override.

Ports:
- clkSelect  in  1  system clock (divided board clock)
- resetGame  in  1  asynchronous, active-high game reset
- new_round  in  1  synchronous single-cycle pulse; starts the next round
- p1_press  in  1  synchronised single-cycle pulse; moves light toward index 0
- p2_press  in  1  synchronised single-cycle pulse; moves light toward index N_POS-1; ignored when cpu_mode=1
- cpu_mode  in  1  1 = player 2 is the computer
- difficulty  in  LFSR_W  computer press threshold
- lights  out  N_POS  one-hot lit position
- pos  out  POS_W  current position index
- p1_score  out  SCORE_W  player 1 round wins
- p2_score  out  SCORE_W  player 2 round wins
- game_state  out  2  PLAY=0, ROUND_OVER=1, GAME_OVER=2
- winner  out  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Reset (resetGame, asynchronous, active-high; clock clkSelect):
  - pos=C, lights = 1<<C, scores=0, state=PLAY, winner=00, LFSR=0.
  - Takes effect immediately, without waiting for a clock edge.
- Opponent:
  - cpu_press = (difficulty > lfsr), unsigned compare, combinational.
  - mv2 = cpu_mode ? cpu_press : p2_press.
  - LFSR is XNOR Fibonacci, shifting every clkSelect edge in all states. All-ones is the lockup state and is never reached from reset.
- PLAY, evaluated at each edge:
  - If new_round=1: pos<=C. This has priority over moves.
  - Else p1_press=1 and mv2=0: pos<=pos-1.
  - Else p1_press=0 and mv2=1: pos<=pos+1.
  - Else both or neither: no change.
- Round end, on the same edge that pos becomes 0:
  - p1_score<=p1_score+1, winner<=01.
  - state<=GAME_OVER if p1_score+1==SCORE_MAX, otherwise ROUND_OVER.
  - The same applies symmetrically for N_POS-1 with p2_score and winner=10.
- ROUND_OVER:
  - Moves ignored; pos and lights frozen at the end position.
  - new_round: pos<=C, winner<=00, state<=PLAY. Scores kept. LFSR is not reset.
- GAME_OVER:
  - All inputs except resetGame are ignored.
  - Outputs hold the final position, scores and winner.
- Score width: scores never exceed SCORE_MAX. No wrap-around is possible.
- Latency: lights and pos change exactly 1 edge after an accepted press pulse.
- lights is always exactly one-hot. pos is always within 0..N_POS-1.
- Illegal state encoding 3: next edge goes to PLAY with pos=C. Scores are kept.

Decomposition:
- Package tug_war_pkg holds:
  - game_state_e enum (PLAY, ROUND_OVER, GAME_OVER)
  - winner constants WIN_NONE, WIN_P1, WIN_P2
  - function lfsr_taps(width), returning the XNOR tap mask for widths 8..16 (10 -> bits 10,7)
- Sub-module lfsr_xnor_n:
  - parameter W; ports clk, reset, rnd[W-1:0]
  - instanced once, on clkSelect/resetGame.
- Everything else (position counter, FSM, scores, one-hot decode) lives in tug_war_engine.

Test Plan (N_POS=9, SCORE_MAX=7, LFSR_W=10):
1. Assert resetGame between clock edges -> immediately pos=4, lights=9'b000010000, scores=0, state=PLAY, winner=00.
2. cpu_mode=0, four p1_press pulses -> pos 3,2,1,0 on successive edges; at pos=0, p1_score=1, state=ROUND_OVER, winner=01. Then p2_press -> no change. Then new_round -> pos=4, winner=00, state=PLAY.
3. Ten cycles with p1_press=p2_press=1 -> pos stays 4. new_round and p1_press in the same cycle -> pos=4.
4. cpu_mode=1, difficulty=0, 200 cycles, p2_press toggling -> pos stays 4. Then difficulty=10'h3FF -> pos 5,6,7,8 on consecutive edges, p2_score=1, winner=10.
5. Seven p2 round wins, each followed by new_round -> after the 7th win p2_score=7, state=GAME_OVER. new_round and presses are then ignored for 20 cycles. resetGame -> all reset values.
6. resetGame pulsed mid-round at pos=2 with p1_score=3 -> immediately pos=4, scores=0, state=PLAY; LFSR restarts from 0, so the LFSR value sequence after reset repeats the sequence seen after the first reset.
